sobel_row_fetch: RTL and testbench
==================================

// Module: sobel_row_fetch
// PURPOSE
//   Producer side of the row interface feeding sobel_accelerator. Reads image words from memory and keeps a
//   3-row sliding window (row1 = top, row2 = middle, row3 = bottom). Presents each window with a valid/ready
//   handshake. Traverses the image one vertical strip (word column) at a time, top to bottom.
// PARAMETERS
//   NUM_ACC      8                Pixels produced per window; must equal `NUM_SOBEL_ACCELERATORS.
//   IDATA_WIDTH  (NUM_ACC+2)*8    Width of one memory word and of one row bus; equals `SOBEL_IDATA_WIDTH.
//   ADDR_WIDTH   16               Memory word-address width.
// PORTS
//   clk                   in   1            Clock; all state changes on the rising edge.
//   reset_b               in   1            Reset, asynchronous, active-low.
//   ctl2srow_start        in   1            Start pulse; sampled only in IDLE.
//   ctl2srow_base_addr    in   ADDR_WIDTH   Word address of image row 0, chunk 0; latched on start.
//   ctl2srow_num_rows     in   10           Image height in rows; latched on start.
//   ctl2srow_num_chunks   in   8            Words per image row; latched on start.
//   srow2ctl_busy         out  1            1 in any state other than IDLE.
//   srow2ctl_done         out  1            One-cycle pulse when the frame completes.
//   srow2mem_rd_en        out  1            Read request, one cycle per word.
//   srow2mem_rd_addr      out  ADDR_WIDTH   Read word address; valid while rd_en = 1.
//   mem2srow_rd_data      in   IDATA_WIDTH  Read data; qualified by rd_valid.
//   mem2srow_rd_valid     in   1            Read data valid; arrives 1 or more cycles after rd_en.
//   srow2sacc_row1_data   out  IDATA_WIDTH  Top row of the window.
//   srow2sacc_row2_data   out  IDATA_WIDTH  Middle row of the window.
//   srow2sacc_row3_data   out  IDATA_WIDTH  Bottom row of the window.
//   srow2swt_valid        out  1            Window valid; the accelerator result is valid combinationally.
//   swt2srow_ready        in   1            Writer accepts the window; transfer happens when valid & ready.
//   srow2swt_out_row      out  10           Image row index of row1 (top row) for the current window.
//   srow2swt_out_chunk    out  8            Chunk (word column) index of the current window.
// BEHAVIOUR
//   Reset: state = IDLE. All outputs, row registers, counters and latched configuration are cleared to 0.
//     Reset is asynchronous, so asserting it mid-frame aborts the frame; no done pulse is produced.
//   FSM states: IDLE, FETCH, WAIT, PRESENT, DONE.
//   IDLE -> FETCH on start, with num_rows >= 3 and num_chunks != 0. Clears row_idx, chunk_idx and fill.
//   IDLE -> DONE on start with num_rows < 3 or num_chunks == 0. No reads are issued.
//   FETCH: drive rd_en = 1 for exactly one cycle.
//     rd_addr = base + row_idx*num_chunks + chunk_idx, computed modulo 2^ADDR_WIDTH. Go to WAIT.
//   WAIT: hold until rd_valid = 1. On the valid cycle, shift the window:
//     row1 <= row2, row2 <= row3, row3 <= rd_data; row_idx++; fill = min(fill+1, 3).
//     If the new fill < 3, go to FETCH; otherwise go to PRESENT.
//   PRESENT: valid = 1; row buses, out_row = row_idx-3 and out_chunk are held stable until accepted.
//     On valid & ready:
//       row_idx < num_rows  -> FETCH.
//       row_idx == num_rows and chunk_idx < num_chunks-1 -> chunk_idx++, row_idx = 0, fill = 0, then FETCH.
//       Otherwise (last window of the frame) -> DONE.
//   DONE: done = 1 for one cycle, then IDLE.
//   Exactly one read is outstanding at a time. rd_valid outside WAIT is ignored.
//   start outside IDLE is ignored. Config inputs are not sampled after start.
//   Windows per strip = num_rows-2. Total windows = (num_rows-2)*num_chunks.
//     Total reads = num_rows*num_chunks; each row is re-read once per strip.
//   Latency with 1-cycle memory: start at edge 0 -> rd_en at cycles 1, 3, 5 -> valid = 1 at cycle 7.
//     Steady state is one window per 3 cycles (PRESENT, FETCH, WAIT) when ready = 1.
//   ready = 0 stalls in PRESENT indefinitely with no reads issued. ready while valid = 0 has no effect.
// TESTING
//   T1 Reset: reset_b = 0 mid-WAIT -> all outputs 0, state IDLE.
//      After release with no start: busy = 0, no rd_en.
//   T2 Minimum frame: base = 0x0100, rows = 3, chunks = 1, 1-cycle memory returning word = addr.
//      -> reads at 0x0100, 0x0101, 0x0102.
//      -> one window at cycle 7: row1/2/3 = 0x100/0x101/0x102, out_row = 0, out_chunk = 0.
//      -> done at cycle 9.
//   T3 Two strips: rows = 4, chunks = 2, base = 0.
//      -> read order 0, 2, 4, 6, 1, 3, 5, 7.
//      -> 4 windows with (row, chunk) = (0,0), (1,0), (0,1), (1,1); exactly one done pulse.
//   T4 Backpressure: in T3, hold ready = 0 for 10 cycles on the 2nd window.
//      -> valid and data stable, no rd_en during the stall, same window sequence afterwards.
//   T5 Degenerate config: start with rows = 2 (or chunks = 0).
//      -> zero reads, zero windows, done pulse 2 cycles after start.
//   T6 Variable memory latency (1..5 cycles, random) and a start pulse while busy.
//      -> start ignored; window data bit-identical to T3; address wrap checked with base = 0xFFFE, rows = 3, chunks = 1.
//      -> reads at 0xFFFE, 0xFFFF, 0x0000.

Source files
------------

// File: rtl/sobel_row_fetch.sv
// -----------------------------------------------------------------------------
// sobel_row_fetch
//
// Producer side of the row interface that feeds sobel_accelerator. Image words
// are read from memory one at a time and kept as a 3-row sliding window:
// row1 is the top row, row2 the middle row and row3 the bottom row. Each full
// window is offered to the writer with a valid/ready handshake. The image is
// walked one vertical strip (word column) at a time, top to bottom, so every
// image row is read once per strip.
//
// Parameters
//   NUM_ACC      pixels produced per window (matches the accelerator count)
//   IDATA_WIDTH  width of one memory word and of each row bus
//   ADDR_WIDTH   memory word-address width; addresses wrap modulo 2^ADDR_WIDTH
//
// Ports
//   clk                  rising-edge clock
//   reset_b              asynchronous active-low reset; aborts any frame
//   ctl2srow_start       start pulse, only honoured while idle
//   ctl2srow_base_addr   word address of row 0 / chunk 0 (latched on start)
//   ctl2srow_num_rows    image height in rows (latched on start)
//   ctl2srow_num_chunks  words per image row (latched on start)
//   srow2ctl_busy        high whenever the block is not idle
//   srow2ctl_done        one-cycle pulse when a frame completes
//   srow2mem_rd_en       one-cycle read request
//   srow2mem_rd_addr     read word address, meaningful while rd_en is high
//   mem2srow_rd_data     read data, qualified by mem2srow_rd_valid
//   mem2srow_rd_valid    read data valid, one or more cycles after rd_en
//   srow2sacc_row1_data  top row of the window
//   srow2sacc_row2_data  middle row of the window
//   srow2sacc_row3_data  bottom row of the window
//   srow2swt_valid       window valid
//   swt2srow_ready       writer accepts the window (transfer on valid & ready)
//   srow2swt_out_row     image row index of row1 for the presented window
//   srow2swt_out_chunk   chunk (word column) index of the presented window
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sobel_row_fetch #(
    parameter int NUM_ACC     = 8,
    parameter int IDATA_WIDTH = (NUM_ACC + 2) * 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   ctl2srow_start,
    input  logic [ADDR_WIDTH-1:0]  ctl2srow_base_addr,
    input  logic [9:0]             ctl2srow_num_rows,
    input  logic [7:0]             ctl2srow_num_chunks,
    output logic                   srow2ctl_busy,
    output logic                   srow2ctl_done,
    output logic                   srow2mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  srow2mem_rd_addr,
    input  logic [IDATA_WIDTH-1:0] mem2srow_rd_data,
    input  logic                   mem2srow_rd_valid,
    output logic [IDATA_WIDTH-1:0] srow2sacc_row1_data,
    output logic [IDATA_WIDTH-1:0] srow2sacc_row2_data,
    output logic [IDATA_WIDTH-1:0] srow2sacc_row3_data,
    output logic                   srow2swt_valid,
    input  logic                   swt2srow_ready,
    output logic [9:0]             srow2swt_out_row,
    output logic [7:0]             srow2swt_out_chunk
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Latched frame configuration
    logic [9:0]             r_num_rows;
    logic [7:0]             r_num_chunks;

    // Traversal position
    logic [9:0]             r_row_idx;     // next image row to be read in this strip
    logic [7:0]             r_chunk_idx;   // current strip
    logic [1:0]             r_fill;        // rows held in the window, saturates at 3

    // Address generation: r_strip_addr = base + chunk_idx, and r_rd_addr steps
    // by num_chunks per read, so no multiplier is needed for row*num_chunks.
    logic [ADDR_WIDTH-1:0]  r_strip_addr;
    logic [ADDR_WIDTH-1:0]  r_rd_addr;

    // Window registers
    logic [IDATA_WIDTH-1:0] r_row1;
    logic [IDATA_WIDTH-1:0] r_row2;
    logic [IDATA_WIDTH-1:0] r_row3;

    logic                   r_done;

    logic                   w_cfg_ok;
    logic                   w_rd_take;
    logic                   w_accept;
    logic                   w_strip_end;
    logic                   w_more_chunks;
    logic                   w_next_strip;
    logic [1:0]             w_fill_inc;
    logic                   w_fetch;
    logic                   w_present;

    // A frame needs at least three rows to form one window and at least one chunk.
    assign w_cfg_ok      = (ctl2srow_num_rows >= 10'd3) && (ctl2srow_num_chunks != 8'd0);
    assign w_rd_take     = (r_state == S_WAIT) && mem2srow_rd_valid;
    assign w_accept      = (r_state == S_PRESENT) && swt2srow_ready;
    assign w_strip_end   = (r_row_idx == r_num_rows);
    // num_chunks is never 0 once a frame runs, so the subtraction cannot underflow.
    assign w_more_chunks = (r_chunk_idx < (r_num_chunks - 8'd1));
    assign w_next_strip  = w_accept && w_strip_end && w_more_chunks;
    assign w_fill_inc    = (r_fill == 2'd3) ? 2'd3 : (r_fill + 2'd1);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_fetch      = 1'b0;
        w_present    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctl2srow_start) begin
                    w_next_state = w_cfg_ok ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                w_fetch      = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // Once the window is full (steady state) every read yields a window.
                if (mem2srow_rd_valid) begin
                    w_next_state = (w_fill_inc == 2'd3) ? S_PRESENT : S_FETCH;
                end
            end
            S_PRESENT: begin
                w_present = 1'b1;
                if (swt2srow_ready) begin
                    if (!w_strip_end || w_more_chunks) begin
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Configuration, traversal counters, addresses and window registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_num_rows   <= '0;
            r_num_chunks <= '0;
            r_row_idx    <= '0;
            r_chunk_idx  <= '0;
            r_fill       <= '0;
            r_strip_addr <= '0;
            r_rd_addr    <= '0;
            r_row1       <= '0;
            r_row2       <= '0;
            r_row3       <= '0;
        end else begin
            if ((r_state == S_IDLE) && ctl2srow_start) begin
                r_num_rows   <= ctl2srow_num_rows;
                r_num_chunks <= ctl2srow_num_chunks;
                r_row_idx    <= '0;
                r_chunk_idx  <= '0;
                r_fill       <= '0;
                r_strip_addr <= ctl2srow_base_addr;
                r_rd_addr    <= ctl2srow_base_addr;
            end

            // The address for the next row of this strip is one image row further.
            if (w_fetch) begin
                r_rd_addr <= r_rd_addr + ADDR_WIDTH'(r_num_chunks);
            end

            if (w_rd_take) begin
                r_row1    <= r_row2;
                r_row2    <= r_row3;
                r_row3    <= mem2srow_rd_data;
                r_row_idx <= r_row_idx + 10'd1;
                r_fill    <= w_fill_inc;
            end

            // Move to the top of the next strip; the window refills from empty.
            if (w_next_strip) begin
                r_chunk_idx  <= r_chunk_idx + 8'd1;
                r_row_idx    <= '0;
                r_fill       <= '0;
                r_strip_addr <= r_strip_addr + ADDR_ONE;
                r_rd_addr    <= r_strip_addr + ADDR_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Done pulse: registered, so it appears the cycle after the DONE state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
        end
    end

    assign srow2ctl_busy       = (r_state != S_IDLE);
    assign srow2ctl_done       = r_done;
    assign srow2mem_rd_en      = w_fetch;
    assign srow2mem_rd_addr    = r_rd_addr;
    assign srow2sacc_row1_data = r_row1;
    assign srow2sacc_row2_data = r_row2;
    assign srow2sacc_row3_data = r_row3;
    assign srow2swt_valid      = w_present;
    // row_idx already points past the bottom row, so the top row is three back.
    // Indices are forced to 0 when no window is presented.
    assign srow2swt_out_row    = w_present ? (r_row_idx - 10'd3) : '0;
    assign srow2swt_out_chunk  = w_present ? r_chunk_idx : '0;

endmodule

// File: tb/tb_sobel_row_fetch.sv
`timescale 1ns/1ps

module tb_sobel_row_fetch;

    localparam int NUM_ACC = 8;
    localparam int IW      = (NUM_ACC + 2) * 8;
    localparam int AW      = 16;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [9:0]    num_rows;
    logic [7:0]    num_chunks;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data;
    logic          rd_valid;
    logic [IW-1:0] row1;
    logic [IW-1:0] row2;
    logic [IW-1:0] row3;
    logic          valid;
    logic          ready;
    logic [9:0]    out_row;
    logic [7:0]    out_chunk;

    always #5 clk = ~clk;

    sobel_row_fetch #(
        .NUM_ACC     (NUM_ACC),
        .IDATA_WIDTH (IW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk                 (clk),
        .reset_b             (reset_b),
        .ctl2srow_start      (start),
        .ctl2srow_base_addr  (base_addr),
        .ctl2srow_num_rows   (num_rows),
        .ctl2srow_num_chunks (num_chunks),
        .srow2ctl_busy       (busy),
        .srow2ctl_done       (done),
        .srow2mem_rd_en      (rd_en),
        .srow2mem_rd_addr    (rd_addr),
        .mem2srow_rd_data    (rd_data),
        .mem2srow_rd_valid   (rd_valid),
        .srow2sacc_row1_data (row1),
        .srow2sacc_row2_data (row2),
        .srow2sacc_row3_data (row3),
        .srow2swt_valid      (valid),
        .swt2srow_ready      (ready),
        .srow2swt_out_row    (out_row),
        .srow2swt_out_chunk  (out_chunk)
    );

    typedef struct {
        logic [IW-1:0] r1;
        logic [IW-1:0] r2;
        logic [IW-1:0] r3;
        logic [9:0]    row;
        logic [7:0]    chunk;
        int            cyc;
    } win_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            lat_min = 1;
    int            lat_max = 1;
    bit            word_mode = 1'b0;
    logic [AW-1:0] q_rd[$];
    int            q_rd_cyc[$];
    win_t          q_win[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            stall_bad = 0;
    int            overlap_bad = 0;
    int            outstanding_bad = 0;

    // Memory contents: either the address itself or a scrambled word per address.
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        if (!word_mode) return IW'(a);
        return {a ^ 16'hA5C3, a + 16'h1357, ~a, a[7:0], a[15:8], a};
    endfunction

    function automatic logic [AW-1:0] img_addr(input logic [AW-1:0] base, input int r,
                                               input int c, input int chunks);
        return AW'(int'(base) + r * chunks + c);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory: one response per request, after a random latency of lat_min..lat_max cycles.
    initial begin : mem_model
        int            cnt;
        logic [AW-1:0] pend_addr;
        cnt       = 0;
        pend_addr = '0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (!reset_b) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        rd_valid = 1'b1;
                        rd_data  = mem_word(pend_addr);
                    end
                end
                if (rd_en) begin
                    if (cnt != 0) outstanding_bad++;
                    pend_addr = rd_addr;
                    cnt       = int'($urandom_range(lat_max, lat_min));
                end
            end
        end
    end

    // Observer: records reads, accepted windows and done pulses; flags stall instability.
    initial begin : monitor
        win_t          w;
        logic          p_stall;
        logic [IW-1:0] p1;
        logic [IW-1:0] p2;
        logic [IW-1:0] p3;
        logic [9:0]    prow;
        logic [7:0]    pch;
        p_stall = 1'b0;
        p1 = '0; p2 = '0; p3 = '0; prow = '0; pch = '0;
        forever begin
            @(negedge clk);
            if (rd_en) begin
                q_rd.push_back(rd_addr);
                q_rd_cyc.push_back(cyc);
            end
            if (rd_en && valid) overlap_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (valid && p_stall &&
                (row1 !== p1 || row2 !== p2 || row3 !== p3 || out_row !== prow || out_chunk !== pch))
                stall_bad++;
            if (valid && ready) begin
                w.r1 = row1; w.r2 = row2; w.r3 = row3;
                w.row = out_row; w.chunk = out_chunk; w.cyc = cyc;
                q_win.push_back(w);
            end
            p_stall = valid && !ready;
            p1 = row1; p2 = row2; p3 = row3; prow = out_row; pch = out_chunk;
        end
    end

    // Runs one frame; optional backpressure on the 2nd window and a stray start mid-frame.
    task automatic run_frame(input logic [AW-1:0] base, input int rows, input int chunks,
                             input bit bp, input bit dup,
                             output int t0, output int rd0, output int win0, output int dn0);
        int k       = 0;
        int extra   = -1;
        int stall_n = 0;
        bit armed   = bp;
        rd0  = q_rd.size();
        win0 = q_win.size();
        dn0  = done_cnt;
        @(posedge clk); #1;
        base_addr  = base;
        num_rows   = 10'(rows);
        num_chunks = 8'(chunks);
        start      = 1'b1;
        t0         = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (k < 3000 && extra != 0) begin
            @(posedge clk); #1;
            k++;
            if (extra > 0) extra--;
            if (extra < 0 && done_cnt > dn0) extra = 4;
            if (armed && ready && stall_n == 0 && q_win.size() == win0 + 1) ready = 1'b0;
            if (!ready && valid) begin
                if (stall_n == 10) begin
                    ready = 1'b1;
                    armed = 1'b0;
                end else begin
                    stall_n++;
                end
            end
            if (dup && k == 4) begin
                start      = 1'b1;
                base_addr  = 16'h7777;
                num_rows   = 10'd2;
                num_chunks = 8'd0;
            end else if (dup && k == 5) begin
                start = 1'b0;
            end
        end
        check("frame_finished", 128'(done_cnt > dn0), 128'd1);
        if (bp) check("stall_cycles", 128'(stall_n), 128'd10);
    endtask

    // Compares a finished frame against the image traversal rules.
    task automatic check_frame(input string tag, input logic [AW-1:0] base, input int rows,
                               input int chunks, input int rd0, input int win0, input int dn0);
        logic [AW-1:0] ea[$];
        win_t          ew[$];
        win_t          w;
        if (rows >= 3 && chunks != 0) begin
            for (int c = 0; c < chunks; c++) begin
                for (int r = 0; r < rows; r++) ea.push_back(img_addr(base, r, c, chunks));
                for (int r = 0; r <= rows - 3; r++) begin
                    w.r1    = mem_word(img_addr(base, r,     c, chunks));
                    w.r2    = mem_word(img_addr(base, r + 1, c, chunks));
                    w.r3    = mem_word(img_addr(base, r + 2, c, chunks));
                    w.row   = 10'(r);
                    w.chunk = 8'(c);
                    w.cyc   = 0;
                    ew.push_back(w);
                end
            end
        end
        check($sformatf("%s_nreads", tag), 128'(q_rd.size() - rd0), 128'(ea.size()));
        for (int i = 0; i < ea.size(); i++)
            if (rd0 + i < q_rd.size())
                check($sformatf("%s_rd%0d", tag, i), 128'(q_rd[rd0 + i]), 128'(ea[i]));
        check($sformatf("%s_nwin", tag), 128'(q_win.size() - win0), 128'(ew.size()));
        for (int i = 0; i < ew.size(); i++) begin
            if (win0 + i < q_win.size()) begin
                check($sformatf("%s_w%0d_row1", tag, i), 128'(q_win[win0 + i].r1), 128'(ew[i].r1));
                check($sformatf("%s_w%0d_row2", tag, i), 128'(q_win[win0 + i].r2), 128'(ew[i].r2));
                check($sformatf("%s_w%0d_row3", tag, i), 128'(q_win[win0 + i].r3), 128'(ew[i].r3));
                check($sformatf("%s_w%0d_pos", tag, i),
                      128'({q_win[win0 + i].row, q_win[win0 + i].chunk}),
                      128'({ew[i].row, ew[i].chunk}));
            end
        end
        check($sformatf("%s_done_pulses", tag), 128'(done_cnt - dn0), 128'd1);
        check($sformatf("%s_stall_stable", tag), 128'(stall_bad), 128'd0);
        check($sformatf("%s_no_read_in_present", tag), 128'(overlap_bad), 128'd0);
        check($sformatf("%s_one_outstanding", tag), 128'(outstanding_bad), 128'd0);
        check($sformatf("%s_idle_after", tag), 128'(busy), 128'd0);
    endtask

    initial begin : main
        int t0;
        int rd0;
        int win0;
        int dn0;
        int k;
        int rd1;

        reset_b    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_rows   = '0;
        num_chunks = '0;
        ready      = 1'b1;

        // Power-up reset state
        repeat (3) @(posedge clk);
        #1;
        check("por_busy",  128'(busy),  128'd0);
        check("por_rd_en", 128'(rd_en), 128'd0);
        check("por_valid", 128'(valid), 128'd0);
        check("por_done",  128'(done),  128'd0);
        reset_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // T1: reset asserted while waiting for read data
        lat_min = 5;
        lat_max = 5;
        rd0 = q_rd.size();
        dn0 = done_cnt;
        base_addr  = 16'h0040;
        num_rows   = 10'd4;
        num_chunks = 8'd2;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (q_rd.size() == rd0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("t1_first_read", 128'(q_rd.size() - rd0), 128'd1);
        check("t1_busy_in_wait", 128'(busy), 128'd1);
        reset_b = 1'b0;
        #1;
        check("t1_busy",     128'(busy),      128'd0);
        check("t1_rd_en",    128'(rd_en),     128'd0);
        check("t1_rd_addr",  128'(rd_addr),   128'd0);
        check("t1_valid",    128'(valid),     128'd0);
        check("t1_done",     128'(done),      128'd0);
        check("t1_row1",     128'(row1),      128'd0);
        check("t1_row2",     128'(row2),      128'd0);
        check("t1_row3",     128'(row3),      128'd0);
        check("t1_out_row",  128'(out_row),   128'd0);
        check("t1_out_chunk",128'(out_chunk), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b1;
        rd1 = q_rd.size();
        repeat (10) @(posedge clk);
        #1;
        check("t1_no_reads_after", 128'(q_rd.size() - rd1), 128'd0);
        check("t1_idle_after",     128'(busy),              128'd0);
        check("t1_no_done",        128'(done_cnt - dn0),    128'd0);

        // T2: minimum frame, 1-cycle memory, word = address
        lat_min   = 1;
        lat_max   = 1;
        word_mode = 1'b0;
        run_frame(16'h0100, 3, 1, 1'b0, 1'b0, t0, rd0, win0, dn0);
        check_frame("t2", 16'h0100, 3, 1, rd0, win0, dn0);
        if (q_rd_cyc.size() >= rd0 + 3) begin
            check("t2_rd_cycle0", 128'(q_rd_cyc[rd0]     - t0), 128'd1);
            check("t2_rd_cycle1", 128'(q_rd_cyc[rd0 + 1] - t0), 128'd3);
            check("t2_rd_cycle2", 128'(q_rd_cyc[rd0 + 2] - t0), 128'd5);
        end
        if (q_win.size() > win0) begin
            check("t2_win_cycle", 128'(q_win[win0].cyc - t0), 128'd7);
            check("t2_win_row1",  128'(q_win[win0].r1), 128'h100);
            check("t2_win_row3",  128'(q_win[win0].r3), 128'h102);
        end
        check("t2_done_cycle", 128'(done_cyc - t0), 128'd9);

        // T3: two strips with scrambled memory contents
        word_mode = 1'b1;
        run_frame(16'h0000, 4, 2, 1'b0, 1'b0, t0, rd0, win0, dn0);
        check_frame("t3", 16'h0000, 4, 2, rd0, win0, dn0);

        // T4: same frame, 2nd window held off for 10 cycles
        run_frame(16'h0000, 4, 2, 1'b1, 1'b0, t0, rd0, win0, dn0);
        check_frame("t4", 16'h0000, 4, 2, rd0, win0, dn0);

        // T5: degenerate configurations
        run_frame(16'h0040, 2, 3, 1'b0, 1'b0, t0, rd0, win0, dn0);
        check_frame("t5_rows2", 16'h0040, 2, 3, rd0, win0, dn0);
        check("t5_rows2_done_cycle", 128'(done_cyc - t0), 128'd2);
        run_frame(16'h0040, 5, 0, 1'b0, 1'b0, t0, rd0, win0, dn0);
        check_frame("t5_chunks0", 16'h0040, 5, 0, rd0, win0, dn0);
        check("t5_chunks0_done_cycle", 128'(done_cyc - t0), 128'd2);

        // T6: random memory latency, stray start and config change while busy
        lat_min = 1;
        lat_max = 5;
        run_frame(16'h0000, 4, 2, 1'b0, 1'b1, t0, rd0, win0, dn0);
        check_frame("t6", 16'h0000, 4, 2, rd0, win0, dn0);
        // Address wrap at the top of the address space
        run_frame(16'hFFFE, 3, 1, 1'b0, 1'b0, t0, rd0, win0, dn0);
        check_frame("t6_wrap", 16'hFFFE, 3, 1, rd0, win0, dn0);
        if (q_rd.size() >= rd0 + 3) begin
            check("t6_wrap_rd0", 128'(q_rd[rd0]),     128'hFFFE);
            check("t6_wrap_rd1", 128'(q_rd[rd0 + 1]), 128'hFFFF);
            check("t6_wrap_rd2", 128'(q_rd[rd0 + 2]), 128'h0000);
        end

        // Random frames with random latency and random backpressure choice
        for (int n = 0; n < 4; n++) begin
            logic [AW-1:0] b;
            int            rr;
            int            cc;
            b  = AW'($urandom);
            rr = int'($urandom_range(7, 3));
            cc = int'($urandom_range(4, 1));
            run_frame(b, rr, cc, 1'($urandom_range(1, 0)), 1'b0, t0, rd0, win0, dn0);
            check_frame($sformatf("rnd%0d", n), b, rr, cc, rd0, win0, dn0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
